// File: rtl/tia_audio_gen.sv
// tia_audio_gen: TIA-style multi-channel tone/noise audio generator.
// Each channel has its own AUDC/AUDF/AUDV registers and poly4/5/9 and
// div31 waveform state. Channel outputs are mixed into one PCM sample.
//
// Ports:
//   clk_i, rst_i      clock, async active-high reset
//   enable_i          colour-clock strobe (prescaled by TICK_DIV)
//   stb_i/we_i/adr_i/dat_i  register write bus (no reads)
//   audio_o           mixed sample, audio_valid_o pulses on update
//   ch_out_o          raw waveform bit per channel
//   pdm_o             1-bit delta-sigma output
//
// Optional feature macro: TIA_AUDIO_DAC_EN (delta-sigma DAC on pdm_o).
// Without it pdm_o is tied low and no accumulator is built.

module tia_audio_gen #(
  parameter int NUM_CH = 2,
  parameter int ADDR_WIDTH = 7,
  parameter logic [ADDR_WIDTH-1:0] AUDC_BASE = 'h15,
  parameter int TICK_DIV = 114,
  parameter int MIX_W = 4 + $clog2(NUM_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [7:0]            dat_i,
  output logic [MIX_W-1:0]      audio_o,
  output logic                  audio_valid_o,
  output logic [NUM_CH-1:0]     ch_out_o,
  output logic                  pdm_o
);

  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TCW-1:0]        r_tcnt;
  logic                  w_tick;
  logic [ADDR_WIDTH-1:0] w_off;
  logic                  w_wr;
  logic [3:0]            w_audv [NUM_CH];
  logic [MIX_W-1:0]      w_mix;
  logic [MIX_W-1:0]      r_audio;
  logic                  r_valid;
  logic                  r_pend;
  logic                  w_unused_dat;

  assign w_unused_dat = ^dat_i[7:5];

  // Offset from the AUDC block start; addresses below the base wrap
  // to large values and fall outside every block.
  assign w_off = adr_i - AUDC_BASE;
  assign w_wr  = stb_i && we_i;

  assign w_tick = enable_i && (r_tcnt == TCW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tcnt <= '0;
    end else if (enable_i) begin
      r_tcnt <= w_tick ? '0 : r_tcnt + TCW'(1);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [3:0] r_audc;
    logic [4:0] r_audf;
    logic [3:0] r_audv;
    logic [4:0] r_fcnt;
    logic [1:0] r_pre3;
    logic [3:0] r_p4;
    logic [4:0] r_p5;
    logic [8:0] r_p9;
    logic [4:0] r_d31;
    logic       r_out;

    logic       w_wr_c;
    logic       w_wr_f;
    logic       w_wr_v;
    logic       w_ctick;
    logic       w_hi;
    logic       w_step;
    logic [3:0] w_p4s;
    logic [4:0] w_p5s;
    logic [8:0] w_p9s;
    logic [4:0] w_d31s;
    logic [3:0] w_p4n;
    logic [4:0] w_p5n;
    logic [8:0] w_p9n;
    logic [4:0] w_d31n;
    logic       w_outn;

    assign w_wr_c = w_wr && (w_off == ADDR_WIDTH'(c));
    assign w_wr_f = w_wr && (w_off == ADDR_WIDTH'(NUM_CH + c));
    assign w_wr_v = w_wr && (w_off == ADDR_WIDTH'(2 * NUM_CH + c));

    // >= so a lowered audf mid-count still terminates the period.
    assign w_ctick = (r_fcnt >= r_audf);
    assign w_hi    = (r_audc[3:2] == 2'b11);
    assign w_step  = w_ctick && (!w_hi || (r_pre3 == 2'd2));

    assign w_p4s  = {r_p4[2:0], r_p4[3] ^ r_p4[2]};
    assign w_p5s  = {r_p5[3:0], r_p5[4] ^ r_p5[2]};
    assign w_p9s  = {r_p9[7:0], r_p9[8] ^ r_p9[4]};
    assign w_d31s = (r_d31 == 5'd30) ? 5'd0 : r_d31 + 5'd1;

    // Only the state a mode uses advances; the rest is held.
    always_comb begin
      w_p4n  = r_p4;
      w_p5n  = r_p5;
      w_p9n  = r_p9;
      w_d31n = r_d31;
      w_outn = r_out;
      case (r_audc)
        4'd0, 4'd11: w_outn = 1'b1;
        4'd1: begin
          w_p4n  = w_p4s;
          w_outn = w_p4s[3];
        end
        4'd2: begin
          w_d31n = w_d31s;
          if (w_d31s == 5'd0) w_p4n = w_p4s;
          w_outn = w_p4n[3];
        end
        4'd3: begin
          w_p5n = w_p5s;
          if (w_p5s[4]) w_p4n = w_p4s;
          w_outn = w_p4n[3];
        end
        4'd4, 4'd5, 4'd12, 4'd13: w_outn = ~r_out;
        4'd6, 4'd10, 4'd14: begin
          w_d31n = w_d31s;
          w_outn = (w_d31s < 5'd13);
        end
        4'd7, 4'd9, 4'd15: begin
          w_p5n  = w_p5s;
          w_outn = w_p5s[4];
        end
        4'd8: begin
          w_p9n  = w_p9s;
          w_outn = w_p9s[8];
        end
        default: w_outn = r_out;
      endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_audc <= '0;
        r_audf <= '0;
        r_audv <= '0;
        r_fcnt <= '0;
        r_pre3 <= '0;
        r_p4   <= 4'hF;
        r_p5   <= 5'h1F;
        r_p9   <= 9'h1FF;
        r_d31  <= '0;
        r_out  <= 1'b0;
      end else begin
        if (w_wr_c) r_audc <= dat_i[3:0];
        if (w_wr_f) r_audf <= dat_i[4:0];
        if (w_wr_v) r_audv <= dat_i[3:0];
        if (w_tick) begin
          r_fcnt <= w_ctick ? 5'd0 : r_fcnt + 5'd1;
          if (w_ctick && w_hi) begin
            r_pre3 <= (r_pre3 == 2'd2) ? 2'd0 : r_pre3 + 2'd1;
          end
          if (w_step) begin
            r_p4  <= w_p4n;
            r_p5  <= w_p5n;
            r_p9  <= w_p9n;
            r_d31 <= w_d31n;
            r_out <= w_outn;
          end
        end
      end
    end

    assign ch_out_o[c] = r_out;
    assign w_audv[c]   = r_audv;
  end

  always_comb begin
    w_mix = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_out_o[c]) w_mix = w_mix + MIX_W'(w_audv[c]);
    end
  end

  // Mix is taken one clock after the tick that updated ch_out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_audio <= '0;
    end else begin
      r_pend  <= w_tick;
      r_valid <= r_pend;
      if (r_pend) r_audio <= w_mix;
    end
  end

  assign audio_o       = r_audio;
  assign audio_valid_o = r_valid;

`ifdef TIA_AUDIO_DAC_EN
  logic [MIX_W:0] r_acc;
  logic [MIX_W:0] w_acc_n;

  // Carry out of the low MIX_W bits is the pulse-density bit.
  assign w_acc_n = {1'b0, r_acc[MIX_W-1:0]} + {1'b0, r_audio};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_n;
    end
  end

  assign pdm_o = r_acc[MIX_W];
`else
  assign pdm_o = 1'b0;
`endif

endmodule
